// File: rtl/layer_sequencer.sv
// Double-buffered sprite descriptor table, walked in layer order once per frame.
// Each enabled slot with valid geometry is handed to the blitter over valid/ready.
module layer_sequencer #(
  parameter int unsigned N_LAYERS = 16,
  parameter int unsigned CW       = 10,
  parameter int unsigned TIMEOUT  = 4096,
  localparam int unsigned LW      = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [LW-1:0] i_wr_idx,
  input  logic          i_wr_layer_en,
  input  logic [CW-1:0] i_wr_inicio_x,
  input  logic [CW-1:0] i_wr_inicio_y,
  input  logic [CW-1:0] i_wr_final_x,
  input  logic [CW-1:0] i_wr_final_y,
  input  logic [CW-1:0] i_wr_fb_x,
  input  logic [CW-1:0] i_wr_fb_y,
  input  logic          i_frame_start,
  input  logic          i_desc_ready,
  input  logic          i_blit_done,
  input  logic          i_err_clr,
  output logic          o_desc_valid,
  output logic [CW-1:0] o_vram_inicio_x,
  output logic [CW-1:0] o_vram_inicio_y,
  output logic [CW-1:0] o_vram_final_x,
  output logic [CW-1:0] o_vram_final_y,
  output logic [CW-1:0] o_fb_x,
  output logic [CW-1:0] o_fb_y,
  output logic [LW-1:0] o_layer_idx,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_bad_desc,
  output logic          o_timeout_err,
  output logic          o_overrun
);

  localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LW:0] N_SLOTS  = (LW + 1)'(N_LAYERS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic          en;
    logic [CW-1:0] ix;
    logic [CW-1:0] iy;
    logic [CW-1:0] fx;
    logic [CW-1:0] fy;
    logic [CW-1:0] fbx;
    logic [CW-1:0] fby;
  } desc_t;

  typedef enum logic [2:0] {StIdle, StScan, StIssue, StWait, StDone} state_e;

  state_e          r_state;
  state_e          w_state_next;
  desc_t           r_shadow [N_LAYERS];
  desc_t           r_active [N_LAYERS];
  logic [6*CW-1:0] r_out;
  logic [LW-1:0]   r_layer_idx;
  logic [LW:0]     r_idx;
  logic [TW-1:0]   r_wait_cnt;
  logic            r_bad_desc;
  logic            r_timeout_err;
  logic            r_overrun;

  desc_t w_wr_desc;
  desc_t w_cur;
  logic  w_wr_ok;
  logic  w_geom_ok;
  logic  w_commit;
  logic  w_load;
  logic  w_idx_inc;
  logic  w_cnt_clr;
  logic  w_set_bad;
  logic  w_set_to;
  logic  w_set_overrun;
  logic  w_desc_valid;
  logic  w_frame_done;

  assign w_wr_desc = {i_wr_layer_en, i_wr_inicio_x, i_wr_inicio_y, i_wr_final_x, i_wr_final_y,
                      i_wr_fb_x, i_wr_fb_y};
  assign w_wr_ok   = i_wr_en && ({1'b0, i_wr_idx} < N_SLOTS);
  assign w_cur     = r_active[r_idx[LW-1:0]];
  assign w_geom_ok = (w_cur.fx >= w_cur.ix) && (w_cur.fy >= w_cur.iy);
  assign w_set_overrun = i_frame_start && (r_state != StIdle);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_load       = 1'b0;
    w_idx_inc    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_set_bad    = 1'b0;
    w_set_to     = 1'b0;
    w_desc_valid = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_frame_start) begin
          w_commit     = 1'b1;
          w_state_next = StScan;
        end
      end
      StScan: begin
        if (r_idx == N_SLOTS) begin
          w_state_next = StDone;
        end else if (w_cur.en && w_geom_ok) begin
          w_load       = 1'b1;
          w_state_next = StIssue;
        end else begin
          w_set_bad = w_cur.en;
          w_idx_inc = 1'b1;
        end
      end
      StIssue: begin
        w_desc_valid = 1'b1;
        if (i_desc_ready) begin
          w_cnt_clr    = 1'b1;
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (i_blit_done) begin
          w_idx_inc    = 1'b1;
          w_state_next = StScan;
        end else if ((TIMEOUT != 0) && (r_wait_cnt == TO_LAST)) begin
          w_set_to     = 1'b1;
          w_idx_inc    = 1'b1;
          w_state_next = StScan;
        end
      end
      StDone: begin
        w_frame_done = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Commit reads the pre-edge shadow, so a same-cycle write only reaches the next frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(N_LAYERS); i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_wr_ok) begin
        r_shadow[i_wr_idx] <= w_wr_desc;
      end
      if (w_commit) begin
        for (int i = 0; i < int'(N_LAYERS); i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx         <= '0;
      r_out         <= '0;
      r_layer_idx   <= '0;
      r_wait_cnt    <= '0;
      r_bad_desc    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_commit) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_load) begin
        r_out       <= {w_cur.ix, w_cur.iy, w_cur.fx, w_cur.fy, w_cur.fbx, w_cur.fby};
        r_layer_idx <= r_idx[LW-1:0];
      end
      if (w_cnt_clr) begin
        r_wait_cnt <= '0;
      end else if (r_state == StWait) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      // Set events take priority over err_clr.
      r_bad_desc    <= w_set_bad     | (r_bad_desc    & ~i_err_clr);
      r_timeout_err <= w_set_to      | (r_timeout_err & ~i_err_clr);
      r_overrun     <= w_set_overrun | (r_overrun     & ~i_err_clr);
    end
  end

  assign {o_vram_inicio_x, o_vram_inicio_y, o_vram_final_x, o_vram_final_y, o_fb_x, o_fb_y} = r_out;
  assign o_layer_idx   = r_layer_idx;
  assign o_desc_valid  = w_desc_valid;
  assign o_frame_done  = w_frame_done;
  assign o_busy        = (r_state != StIdle);
  assign o_bad_desc    = r_bad_desc;
  assign o_timeout_err = r_timeout_err;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: single-slot vector table plus multi-cycle sequences.
module tb_layer_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 10;
  localparam int unsigned TO = 8;
  localparam int unsigned LW = 2;

  logic          i_clk;
  logic          i_reset;
  logic          i_wr_en;
  logic [LW-1:0] i_wr_idx;
  logic          i_wr_layer_en;
  logic [CW-1:0] i_wr_inicio_x, i_wr_inicio_y, i_wr_final_x, i_wr_final_y, i_wr_fb_x, i_wr_fb_y;
  logic          i_frame_start, i_desc_ready, i_blit_done, i_err_clr;
  logic          o_desc_valid;
  logic [CW-1:0] o_vram_inicio_x, o_vram_inicio_y, o_vram_final_x, o_vram_final_y, o_fb_x, o_fb_y;
  logic [LW-1:0] o_layer_idx;
  logic          o_busy, o_frame_done, o_bad_desc, o_timeout_err, o_overrun;

  layer_sequencer #(
    .N_LAYERS (N),
    .CW       (CW),
    .TIMEOUT  (TO)
  ) u_dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_wr_en         (i_wr_en),
    .i_wr_idx        (i_wr_idx),
    .i_wr_layer_en   (i_wr_layer_en),
    .i_wr_inicio_x   (i_wr_inicio_x),
    .i_wr_inicio_y   (i_wr_inicio_y),
    .i_wr_final_x    (i_wr_final_x),
    .i_wr_final_y    (i_wr_final_y),
    .i_wr_fb_x       (i_wr_fb_x),
    .i_wr_fb_y       (i_wr_fb_y),
    .i_frame_start   (i_frame_start),
    .i_desc_ready    (i_desc_ready),
    .i_blit_done     (i_blit_done),
    .i_err_clr       (i_err_clr),
    .o_desc_valid    (o_desc_valid),
    .o_vram_inicio_x (o_vram_inicio_x),
    .o_vram_inicio_y (o_vram_inicio_y),
    .o_vram_final_x  (o_vram_final_x),
    .o_vram_final_y  (o_vram_final_y),
    .o_fb_x          (o_fb_x),
    .o_fb_y          (o_fb_y),
    .o_layer_idx     (o_layer_idx),
    .o_busy          (o_busy),
    .o_frame_done    (o_frame_done),
    .o_bad_desc      (o_bad_desc),
    .o_timeout_err   (o_timeout_err),
    .o_overrun       (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int slot;
    bit en;
    int ix, iy, fx, fy, fbx, fby;
    bit exp_iss;
    bit exp_bad;
    int exp_done_k;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [59:0] iss_desc [8];
  int          iss_slot [8];
  int          iss_k    [8];
  int          n_iss, n_done, done_k;
  int          inj_k = -1;
  int          inj_slot;
  logic [59:0] inj_desc;

  function automatic logic [59:0] pack6(input int a, input int b, input int c, input int d,
                                        input int e, input int f);
    return {10'(a), 10'(b), 10'(c), 10'(d), 10'(e), 10'(f)};
  endfunction

  function automatic logic [59:0] out_desc();
    return {o_vram_inicio_x, o_vram_inicio_y, o_vram_final_x, o_vram_final_y, o_fb_x, o_fb_y};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic wr(input int slot, input bit en, input logic [59:0] d);
    i_wr_en       = 1'b1;
    i_wr_idx      = LW'(slot);
    i_wr_layer_en = en;
    {i_wr_inicio_x, i_wr_inicio_y, i_wr_final_x, i_wr_final_y, i_wr_fb_x, i_wr_fb_y} = d;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  // k counts negedges after the frame_start edge; blit_done is sampled 3 edges after each transfer.
  task automatic run_frame(input bit give_done);
    int cd;
    bit finished;
    cd = 0; finished = 0; n_iss = 0; n_done = 0; done_k = -1;
    i_frame_start = 1'b1;
    @(negedge i_clk);
    i_frame_start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      i_blit_done = 1'b0; i_frame_start = 1'b0; i_err_clr = 1'b0; i_wr_en = 1'b0;
      if (k == inj_k) begin
        i_frame_start = 1'b1; i_err_clr = 1'b1; i_wr_en = 1'b1;
        i_wr_idx = LW'(inj_slot); i_wr_layer_en = 1'b1;
        {i_wr_inicio_x, i_wr_inicio_y, i_wr_final_x, i_wr_final_y, i_wr_fb_x, i_wr_fb_y} = inj_desc;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0 && give_done) i_blit_done = 1'b1;
      end
      if (o_desc_valid && i_desc_ready) begin
        if (n_iss < 8) begin
          iss_desc[n_iss] = out_desc();
          iss_slot[n_iss] = int'(o_layer_idx);
          iss_k[n_iss]    = k;
        end
        n_iss++;
        cd = 3;
      end
      if (o_frame_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 2) begin
        finished = 1;
        break;
      end
      @(negedge i_clk);
    end
    i_blit_done = 1'b0; i_frame_start = 1'b0; i_err_clr = 1'b0; i_wr_en = 1'b0;
    inj_k = -1;
    check("frame_complete", finished, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    logic [59:0] da, db, dc;
    bit seen;
    da = pack6(0, 0, 159, 119, 0, 0);
    db = pack6(0, 240, 39, 273, 55, 74);
    dc = pack6(3, 3, 20, 20, 100, 100);
    vecs[0] = '{0, 1, 0, 0, 159, 119, 0, 0, 1, 0, 9};
    vecs[1] = '{1, 1, 5, 0, 4, 10, 0, 0, 0, 1, 5};
    vecs[2] = '{2, 1, 0, 240, 39, 273, 55, 74, 1, 0, 9};
    vecs[3] = '{3, 1, 7, 9, 7, 9, 1023, 1023, 1, 0, 9};
    vecs[4] = '{1, 1, 0, 20, 10, 19, 0, 0, 0, 1, 5};
    vecs[5] = '{2, 0, 0, 0, 10, 10, 0, 0, 0, 0, 5};
    vecs[6] = '{3, 1, 1023, 1023, 1023, 1023, 0, 0, 1, 0, 9};

    i_reset = 1'b1; i_wr_en = 1'b0; i_wr_idx = '0; i_wr_layer_en = 1'b0;
    {i_wr_inicio_x, i_wr_inicio_y, i_wr_final_x, i_wr_final_y, i_wr_fb_x, i_wr_fb_y} = '0;
    i_frame_start = 1'b0; i_desc_ready = 1'b1; i_blit_done = 1'b0; i_err_clr = 1'b0;
    @(negedge i_clk);
    do_reset();
    check("reset_desc", out_desc(), 60'd0);
    check("reset_ctl", {o_desc_valid, o_busy, o_frame_done, o_bad_desc, o_timeout_err, o_overrun,
                        o_layer_idx}, 8'd0);

    // Single-slot vectors: geometry boundaries, disabled slot, extreme coordinates.
    for (int i = 0; i < 7; i++) begin
      logic [59:0] exp_d;
      exp_d = pack6(vecs[i].ix, vecs[i].iy, vecs[i].fx, vecs[i].fy, vecs[i].fbx, vecs[i].fby);
      do_reset();
      wr(vecs[i].slot, vecs[i].en, exp_d);
      run_frame(1);
      check($sformatf("vec%0d_n_iss", i), n_iss, vecs[i].exp_iss);
      if (vecs[i].exp_iss) begin
        check($sformatf("vec%0d_desc", i), iss_desc[0], exp_d);
        check($sformatf("vec%0d_slot", i), iss_slot[0], vecs[i].slot);
        check($sformatf("vec%0d_issue_k", i), iss_k[0], vecs[i].slot + 1);
      end
      check($sformatf("vec%0d_bad", i), o_bad_desc, vecs[i].exp_bad);
      check($sformatf("vec%0d_done_k", i), done_k, vecs[i].exp_done_k);
      check($sformatf("vec%0d_done_pulses", i), n_done, 1);
      i_err_clr = 1'b1;
      @(negedge i_clk);
      i_err_clr = 1'b0;
      check($sformatf("vec%0d_err_clr", i), o_bad_desc, 0);
    end

    // Two layers issued in slot order.
    do_reset();
    wr(0, 1, da);
    wr(2, 1, db);
    run_frame(1);
    check("t1_n_iss", n_iss, 2);
    check("t1_slot0", iss_slot[0], 0);
    check("t1_desc0", iss_desc[0], da);
    check("t1_first_valid_k", iss_k[0], 1);
    check("t1_slot1", iss_slot[1], 2);
    check("t1_desc1", iss_desc[1], db);
    check("t1_issue1_k", iss_k[1], 7);
    check("t1_done_k", done_k, 13);
    check("t1_done_pulses", n_done, 1);
    check("t1_idle", o_busy, 0);

    // Backpressure in ISSUE holds the descriptor.
    do_reset();
    wr(0, 1, da);
    i_desc_ready = 1'b0;
    i_frame_start = 1'b1;
    @(negedge i_clk);
    i_frame_start = 1'b0;
    @(negedge i_clk);
    for (int j = 0; j < 5; j++) begin
      check("t2_valid_held", o_desc_valid, 1);
      check("t2_desc_held", out_desc(), da);
      @(negedge i_clk);
    end
    i_desc_ready = 1'b1;
    @(negedge i_clk);
    check("t2_wait_valid", o_desc_valid, 0);
    check("t2_wait_desc", out_desc(), da);
    check("t2_wait_busy", o_busy, 1);
    i_blit_done = 1'b1;
    @(negedge i_clk);
    i_blit_done = 1'b0;
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      if (o_frame_done) begin
        seen = 1;
        break;
      end
      @(negedge i_clk);
    end
    check("t2_frame_done", seen, 1);

    // frame_start + err_clr + shadow write while waiting on the blitter.
    do_reset();
    wr(0, 1, da);
    inj_k = 2; inj_slot = 2; inj_desc = db;
    run_frame(1);
    check("t4_overrun", o_overrun, 1);
    check("t4_n_iss", n_iss, 1);
    check("t4_slot0", iss_slot[0], 0);
    check("t4_done_k", done_k, 9);
    run_frame(1);
    check("t4_next_n_iss", n_iss, 2);
    check("t4_next_slot1", iss_slot[1], 2);
    check("t4_next_desc1", iss_desc[1], db);
    check("t4_next_issue1_k", iss_k[1], 7);

    // No blit_done: each wait ends after TIMEOUT cycles.
    do_reset();
    wr(0, 1, da);
    wr(1, 1, dc);
    run_frame(0);
    check("t5_n_iss", n_iss, 2);
    check("t5_issue0_k", iss_k[0], 1);
    check("t5_issue1_k", iss_k[1], 11);
    check("t5_slot1", iss_slot[1], 1);
    check("t5_timeout_err", o_timeout_err, 1);
    check("t5_done_k", done_k, 23);

    // Reset mid-wait aborts and clears both tables.
    do_reset();
    wr(0, 1, da);
    i_frame_start = 1'b1;
    @(negedge i_clk);
    i_frame_start = 1'b0;
    @(negedge i_clk);
    check("t6_valid", o_desc_valid, 1);
    @(negedge i_clk);
    check("t6_wait_busy", o_busy, 1);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("t6_rst_valid", o_desc_valid, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_desc", out_desc(), 60'd0);
    check("t6_rst_done", o_frame_done, 0);
    i_reset = 1'b0;
    run_frame(1);
    check("t6_n_iss", n_iss, 0);
    check("t6_done_k", done_k, N + 1);
    check("t6_done_pulses", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
